sdram_port_arbiter: RTL

SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

---
 rtl/sdram_arb_pkg.sv | 22 ++
 rtl/sdram_port_arbiter_rr.sv | 35 +++
 rtl/sdram_port_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM port arbiter.
// The state encoding lives here so the arbiter and any debug logic decode it the same way.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT_RD = 2'd2,
    ST_DONE    = 2'd3
  } arb_state_e;

  localparam int DW             = 16;
  localparam int AW             = 32;
  localparam int CNT_W          = 16;
  localparam int RD_TIMEOUT_DEF = 100;

  // Width of a client index; a single client still needs a 1-bit index.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sdram_port_arbiter_rr.sv
// Combinational round-robin picker: searches upward from last_grant+1 and wraps,
// so the client served most recently has the lowest priority.
module rr_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NCLI = 2
) (
  input  logic [NCLI-1:0]         req_i,
  input  logic [idx_w(NCLI)-1:0]  last_grant_i,
  output logic [idx_w(NCLI)-1:0]  grant_o,
  output logic                    valid_o
);

  localparam int GW = idx_w(NCLI);

  int              cand;
  logic [GW-1:0]   cand_idx;

  // Walk the offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    grant_o  = '0;
    valid_o  = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = NCLI; k >= 1; k--) begin
      cand     = (int'(last_grant_i) + k) % NCLI;
      cand_idx = GW'(cand);
      if (req_i[cand_idx]) begin
        grant_o = cand_idx;
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Multi-client front end for an Avalon-MM SDRAM port: one transaction in flight,
// round-robin client selection, and a read timeout that completes with an error pulse.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NCLI       = 2,
  parameter int RD_TIMEOUT = RD_TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NCLI-1:0]      cli_req,
  input  logic [NCLI-1:0]      cli_wr,
  input  logic [AW*NCLI-1:0]   cli_addr,
  input  logic [DW*NCLI-1:0]   cli_wdata,
  output logic [NCLI-1:0]      cli_ack,
  output logic [NCLI-1:0]      cli_err,
  output logic [DW-1:0]        cli_rdata,
  output logic                 busy,
  output logic [AW-1:0]        master_address,
  output logic [1:0]           master_byteenable,
  output logic                 master_read,
  output logic                 master_write,
  output logic [DW-1:0]        master_writedata,
  input  logic                 master_waitrequest,
  input  logic [DW-1:0]        master_readdata,
  input  logic                 master_readdatavalid
);

  localparam int              GW      = idx_w(NCLI);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(RD_TIMEOUT - 1);

  arb_state_e        state_q;
  logic [GW-1:0]     last_grant_q, grant_q;
  logic              wr_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NCLI-1:0]   cli_ack_q, cli_err_q;
  logic [DW-1:0]     cli_rdata_q;
  logic              busy_q, master_read_q, master_write_q;
  logic [AW-1:0]     master_address_q;
  logic [DW-1:0]     master_writedata_q;

  logic [GW-1:0]     gnt_idx;
  logic              gnt_valid;
  logic              sel_wr;
  logic [AW-1:0]     sel_addr;
  logic [DW-1:0]     sel_wdata;
  logic [NCLI-1:0]   grant_oh;

  rr_arbiter #(.NCLI(NCLI)) u_rr (
    .req_i        (cli_req),
    .last_grant_i (last_grant_q),
    .grant_o      (gnt_idx),
    .valid_o      (gnt_valid)
  );

  always_comb begin
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NCLI; i++) begin
      if (gnt_idx == GW'(i)) begin
        sel_wr    = cli_wr[i];
        sel_addr  = cli_addr[i*AW +: AW];
        sel_wdata = cli_wdata[i*DW +: DW];
      end
    end
  end

  assign grant_oh = NCLI'(1) << grant_q;
  assign cnt_d    = cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q            <= ST_IDLE;
      last_grant_q       <= GW'(NCLI - 1);
      grant_q            <= '0;
      wr_q               <= 1'b0;
      cnt_q              <= '0;
      cli_ack_q          <= '0;
      cli_err_q          <= '0;
      cli_rdata_q        <= '0;
      busy_q             <= 1'b0;
      master_read_q      <= 1'b0;
      master_write_q     <= 1'b0;
      master_address_q   <= '0;
      master_writedata_q <= '0;
    end else begin
      cli_ack_q <= '0;
      cli_err_q <= '0;
      unique case (state_q)
        ST_IDLE: begin
          if (gnt_valid) begin
            grant_q            <= gnt_idx;
            wr_q               <= sel_wr;
            master_address_q   <= sel_addr;
            master_writedata_q <= sel_wdata;
            master_read_q      <= !sel_wr;
            master_write_q     <= sel_wr;
            busy_q             <= 1'b1;
            state_q            <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!master_waitrequest) begin
            master_read_q  <= 1'b0;
            master_write_q <= 1'b0;
            cnt_q          <= '0;
            if (wr_q) begin
              cli_ack_q <= grant_oh;
              state_q   <= ST_DONE;
            end else begin
              state_q   <= ST_WAIT_RD;
            end
          end
        end
        ST_WAIT_RD: begin
          cnt_q <= cnt_d;
          // Valid data wins over a timeout landing in the same cycle.
          if (master_readdatavalid) begin
            cli_rdata_q <= master_readdata;
            cli_ack_q   <= grant_oh;
            state_q     <= ST_DONE;
          end else if (cnt_d == TO_LAST) begin
            cli_ack_q <= grant_oh;
            cli_err_q <= grant_oh;
            state_q   <= ST_DONE;
          end
        end
        ST_DONE: begin
          last_grant_q <= grant_q;
          busy_q       <= 1'b0;
          state_q      <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cli_ack           = cli_ack_q;
  assign cli_err           = cli_err_q;
  assign cli_rdata         = cli_rdata_q;
  assign busy              = busy_q;
  assign master_address    = master_address_q;
  assign master_byteenable = 2'b11;
  assign master_read       = master_read_q;
  assign master_write      = master_write_q;
  assign master_writedata  = master_writedata_q;

endmodule
